// File: rtl/pipe_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pipe_fetch_pkg
//   Shared constants for the fetch stage.
//   - PC_SEL_*   : next-PC source codes driven by the decode controller.
//   - NOP_INST   : encoding loaded into IF/ID as a bubble (sll $0,$0,0).
//   - EXC_VECTOR : exception entry address.
//   - word_align : clears the two byte-offset bits of an address.
// -----------------------------------------------------------------------------
package pipe_fetch_pkg;

    localparam logic [2:0] PC_SEL_SEQ = 3'd0;
    localparam logic [2:0] PC_SEL_JR  = 3'd1;
    localparam logic [2:0] PC_SEL_BR  = 3'd2;
    localparam logic [2:0] PC_SEL_J   = 3'd3;
    localparam logic [2:0] PC_SEL_EXC = 3'd4;

    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_fetch_pc_next_mux.sv
// -----------------------------------------------------------------------------
// pipe_fetch_pc_next_mux
//   Combinational next-PC selection for the fetch stage.
//   Ports:
//     pc4           in  32  sequential successor of the current PC
//     pc_mux_select in  3   source select from decode (5..7 fall back to pc4)
//     id_read_pc    in  32  jr/jalr target
//     id_bpc        in  32  branch target
//     id_jpc        in  32  j/jal target
//     next_pc       out 32  selected target with bits [1:0] forced to 00
//     misaligned    out 1   a redirect was selected whose raw target[1:0] != 0
// -----------------------------------------------------------------------------
module pipe_fetch_pc_next_mux
    import pipe_fetch_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic [2:0]  pc_mux_select,
    input  logic [31:0] id_read_pc,
    input  logic [31:0] id_bpc,
    input  logic [31:0] id_jpc,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] target;
    logic        redirect;

    // NOTE: every signal assigned in this block gets a default at the top, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        target   = pc4;
        redirect = 1'b1;
        case (pc_mux_select)
            PC_SEL_JR:  target = id_read_pc;
            PC_SEL_BR:  target = id_bpc;
            PC_SEL_J:   target = id_jpc;
            PC_SEL_EXC: target = EXC_VECTOR;
            default: begin
                // PC_SEL_SEQ and the reserved codes both mean "fall through".
                target   = pc4;
                redirect = 1'b0;
            end
        endcase
        next_pc    = word_align(target);
        misaligned = redirect && (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pipe_fetch.sv
// -----------------------------------------------------------------------------
// pipe_fetch
//   Instruction-fetch stage plus the IF/ID pipeline register. MIPS delay-slot
//   semantics: the instruction fetched behind a branch/jump always enters ID.
//   Ports:
//     clk, rst          clock (rising edge), synchronous active-high reset
//     stall             freeze PC, IF/ID and the fetch counter
//     pc_mux_select     next-PC source from decode
//     id_read_pc        jr/jalr target
//     id_bpc, id_jpc    branch / jump targets
//     imem_addr         word address into combinational IMEM
//     imem_rdata        instruction at imem_addr, same cycle
//     if_pc             current fetch PC
//     id_pc4, id_inst   registered PC+4 and instruction for decode
//     id_valid          ID slot holds a real instruction (0 = bubble)
//     pc_misaligned     sticky flag: some redirect target had [1:0] != 0
//     fetch_count       instructions latched into IF/ID since reset (wraps)
// -----------------------------------------------------------------------------
module pipe_fetch
    import pipe_fetch_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
    parameter int          IMEM_AW   = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [2:0]         pc_mux_select,
    input  logic [31:0]        id_read_pc,
    input  logic [31:0]        id_bpc,
    input  logic [31:0]        id_jpc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        if_pc,
    output logic [31:0]        id_pc4,
    output logic [31:0]        id_inst,
    output logic               id_valid,
    output logic               pc_misaligned,
    output logic [31:0]        fetch_count
);

    logic [31:0] pc_q,          pc_d;
    logic [31:0] id_pc4_q,      id_pc4_d;
    logic [31:0] id_inst_q,     id_inst_d;
    logic        id_valid_q,    id_valid_d;
    logic        misaligned_q,  misaligned_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        redirect_misaligned;
    logic [31:0] pc_offset;
    logic        unused_offset_bits;

    assign pc4       = pc_q + 32'd4;
    // Out-of-range PCs simply wrap into the IMEM index space.
    assign pc_offset = pc_q - TEXT_BASE;
    assign imem_addr = pc_offset[IMEM_AW+1:2];
    assign unused_offset_bits = ^{pc_offset[31:IMEM_AW+2], pc_offset[1:0]};

    pipe_fetch_pc_next_mux u_pc_next_mux (
        .pc4           (pc4),
        .pc_mux_select (pc_mux_select),
        .id_read_pc    (id_read_pc),
        .id_bpc        (id_bpc),
        .id_jpc        (id_jpc),
        .next_pc       (next_pc),
        .misaligned    (redirect_misaligned)
    );

    always_comb begin
        pc_d          = pc_q;
        id_pc4_d      = id_pc4_q;
        id_inst_d     = id_inst_q;
        id_valid_d    = id_valid_q;
        misaligned_d  = misaligned_q;
        fetch_count_d = fetch_count_q;
        // While stalled, the select is ignored entirely (including the
        // misalign check); decode re-presents the redirect afterwards.
        if (!stall) begin
            pc_d          = next_pc;
            id_pc4_d      = pc4;
            id_inst_d     = imem_rdata;
            id_valid_d    = 1'b1;
            misaligned_d  = misaligned_q | redirect_misaligned;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= TEXT_BASE;
            id_pc4_q      <= 32'd0;
            id_inst_q     <= NOP_INST;
            id_valid_q    <= 1'b0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            id_pc4_q      <= id_pc4_d;
            id_inst_q     <= id_inst_d;
            id_valid_q    <= id_valid_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign if_pc         = pc_q;
    assign id_pc4        = id_pc4_q;
    assign id_inst       = id_inst_q;
    assign id_valid      = id_valid_q;
    assign pc_misaligned = misaligned_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// -----------------------------------------------------------------------------
// tb_pipe_fetch
//   Directed scenarios followed by a randomized run, all compared against a
//   behavioural model of the fetch stage (PC, IF/ID contents, counter, flag).
// -----------------------------------------------------------------------------
module tb_pipe_fetch;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam int          IMEM_AW   = 11;
    localparam int          IMEM_WORDS = 1 << IMEM_AW;

    logic               clk;
    logic               rst;
    logic               stall;
    logic [2:0]         pc_mux_select;
    logic [31:0]        id_read_pc;
    logic [31:0]        id_bpc;
    logic [31:0]        id_jpc;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        if_pc;
    logic [31:0]        id_pc4;
    logic [31:0]        id_inst;
    logic               id_valid;
    logic               pc_misaligned;
    logic [31:0]        fetch_count;

    logic [31:0] imem [IMEM_WORDS];

    int total;
    int bad;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_inst;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] m_cnt;

    pipe_fetch #(
        .TEXT_BASE (TEXT_BASE),
        .IMEM_AW   (IMEM_AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc_mux_select (pc_mux_select),
        .id_read_pc    (id_read_pc),
        .id_bpc        (id_bpc),
        .id_jpc        (id_jpc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_pc         (if_pc),
        .id_pc4        (id_pc4),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .pc_misaligned (pc_misaligned),
        .fetch_count   (fetch_count)
    );

    assign imem_rdata = imem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word index of a byte address in the wrapping IMEM.
    function automatic int word_index(input logic [31:0] pc);
        return int'(((pc - TEXT_BASE) / 4) % IMEM_WORDS);
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".if_pc"},       if_pc,                  m_pc);
        check({tag, ".imem_addr"},   32'(imem_addr),         32'(word_index(m_pc)));
        check({tag, ".id_pc4"},      id_pc4,                 m_pc4);
        check({tag, ".id_inst"},     id_inst,                m_inst);
        check({tag, ".id_valid"},    {31'd0, id_valid},      {31'd0, m_valid});
        check({tag, ".misaligned"},  {31'd0, pc_misaligned}, {31'd0, m_mis});
        check({tag, ".fetch_count"}, fetch_count,            m_cnt);
    endtask

    // Advance the model by one edge using the currently driven inputs, clock
    // the DUT, then compare everything 1 ns after the edge.
    task automatic tick(input string tag);
        logic [31:0] target;
        bit          redirect;
        if (rst) begin
            m_pc    = TEXT_BASE;
            m_pc4   = 32'd0;
            m_inst  = 32'd0;
            m_valid = 1'b0;
            m_mis   = 1'b0;
            m_cnt   = 32'd0;
        end else if (!stall) begin
            redirect = 1'b1;
            case (pc_mux_select)
                3'd1:    target = id_read_pc;
                3'd2:    target = id_bpc;
                3'd3:    target = id_jpc;
                3'd4:    target = 32'h0040_0004;
                default: begin target = m_pc + 32'd4; redirect = 1'b0; end
            endcase
            if (redirect && (target % 4 != 0)) m_mis = 1'b1;
            m_inst  = imem[word_index(m_pc)];
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = target - (target % 4);
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = TEXT_BASE + ($urandom & 32'h0000_1FFC);
        if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) t = $urandom;
        return t;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < IMEM_WORDS; k++)
            imem[k] = (k < 64) ? 32'(k + 1) : $urandom;

        m_pc = 32'd0; m_pc4 = 32'd0; m_inst = 32'd0;
        m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'd0;

        rst = 1'b1; stall = 1'b0; pc_mux_select = 3'd0;
        id_read_pc = 32'd0; id_bpc = 32'd0; id_jpc = 32'd0;
        #2;

        // 1. Reset state, then four free-running fetches.
        tick("reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick("seq");
        check("seq.count4", fetch_count, 32'd4);
        check("seq.inst4",  id_inst,     32'd4);

        // 2. Branch redirect: the delay slot still enters ID.
        pc_mux_select = 3'd2; id_bpc = 32'h0040_0040;
        tick("branch");
        check("branch.target", if_pc,  32'h0040_0040);
        check("branch.slot",   id_pc4, 32'h0040_0014);
        pc_mux_select = 3'd0;

        // 3. Stall three cycles with a jump presented: nothing moves.
        stall = 1'b1; pc_mux_select = 3'd3; id_jpc = 32'h0040_0100;
        for (int i = 0; i < 3; i++) tick("stall");
        check("stall.pc_held", if_pc, 32'h0040_0040);
        stall = 1'b0; pc_mux_select = 3'd0;
        for (int i = 0; i < 3; i++) tick("release");

        // 4. Misaligned jr target: aligned PC, sticky flag.
        pc_mux_select = 3'd1; id_read_pc = 32'h0040_0022;
        tick("jr_mis");
        check("jr_mis.pc", if_pc, 32'h0040_0020);
        pc_mux_select = 3'd2; id_bpc = 32'h0040_0080;
        tick("sticky");
        pc_mux_select = 3'd4;
        tick("exc");
        check("exc.vector", if_pc, 32'h0040_0004);
        pc_mux_select = 3'd6;
        tick("reserved");

        // 5. Reset wins over stall and redirect.
        stall = 1'b1; pc_mux_select = 3'd2; rst = 1'b1;
        tick("mid_reset");
        check("mid_reset.pc", if_pc, TEXT_BASE);
        rst = 1'b0; stall = 1'b0; pc_mux_select = 3'd0;
        tick("post_reset");

        // 6. PC wrap at the top of the address space.
        pc_mux_select = 3'd3; id_jpc = 32'hFFFF_FFFC;
        tick("jump_top");
        pc_mux_select = 3'd0;
        tick("wrap");
        check("wrap.pc4", id_pc4, 32'h0000_0000);
        tick("below_base");
        check("wrap.no_x",
              {31'd0, $isunknown({imem_addr, if_pc, id_pc4, id_inst, id_valid,
                                  pc_misaligned, fetch_count})},
              32'd0);

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 59) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            pc_mux_select = 3'($urandom_range(0, 7));
            id_read_pc    = rand_target();
            id_bpc        = rand_target();
            id_jpc        = rand_target();
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
